wc_pin_bridge: RTL
==================

// Module: wc_pin_bridge
// PURPOSE
//   Pad-side adapter between a narrow chip pin bus and a wide Winograd core data path.
//   - Deserialises PIN_W-bit input beats into CORE_W-bit words for the core (valid/ready).
//   - Serialises core result words back onto PIN_W output pins through an output FIFO.
//   - Replaces the fixed 10-bit one-word-per-cycle pin mapping, so that cores wider than
//     the pad ring can be bonded out.
//   - Sits between the pad cells (XMD inputs, YA2GSD outputs) and the WC_* core.
// PARAMETERS
//   PIN_W      10  pin bus width, in each direction
//   CORE_W     40  core word width; must be an integer multiple of PIN_W
//   FIFO_DEPTH 4   output FIFO depth in core words; power of two, >= 2
//   LSB_FIRST  1   1: beat 0 carries bits [PIN_W-1:0]; 0: beat 0 carries the MSB slice
//   BEATS = CORE_W/PIN_W is a localparam, not overridable.
// PORTS
//   clk            in   1       single clock, rising-edge
//   rst            in   1       reset
//   pin_d          in   PIN_W   input beat from pads
//   pin_d_vld      in   1       pin_d holds a valid beat this cycle (no backpressure to pins)
//   core_in_data   out  CORE_W  assembled word to core
//   core_in_vld    out  1       core_in_data valid
//   core_in_rdy    in   1       core accepts word (transfer = vld & rdy)
//   core_out_data  in   CORE_W  result word from core
//   core_out_vld   in   1       result valid
//   core_out_rdy   out  1       FIFO not full
//   pin_z          out  PIN_W   output beat to pads
//   pin_z_vld      out  1       pin_z holds a valid beat
//   err_ovf        out  1       sticky: an input word was dropped
// BEHAVIOUR
//   Interface: one clock; reset is asynchronous and active-low.
//   Reset state: all outputs 0, beat counters 0, FIFO empty, serializer idle.
//     - Takes effect immediately on assertion. Deasserting rst is synchronised externally.
//   Input path:
//     - Each clk edge with pin_d_vld=1 captures pin_d into slot beat_cnt of the assembly register.
//     - beat_cnt advances modulo BEATS.
//     - Idle cycles (pin_d_vld=0) hold beat_cnt; beats of one word need not be contiguous.
//     - At the edge capturing beat BEATS-1, the complete word loads the holding register and
//       core_in_vld=1 from that edge on, so there are 0 cycles of extra latency.
//     - core_in_vld stays high, with data stable, until a vld&rdy edge.
//   Input simultaneous events:
//     - Word completes while holding is empty, or holding is valid and core_in_rdy=1:
//       the new word loads and vld remains 1.
//     - Word completes while holding is valid and core_in_rdy=0: the new word is dropped
//       and err_ovf is set. err_ovf is cleared only by rst. beat_cnt wraps normally.
//   Output FIFO:
//     - core_out_rdy = !full, combinational from registered occupancy.
//     - A push happens on an edge with core_out_vld & core_out_rdy.
//     - Push and pop on the same edge are allowed whenever not full; occupancy is unchanged.
//     - When full, a pop raises core_out_rdy in the following cycle.
//   Serializer, 2-state FSM IDLE/SHIFT:
//     - IDLE and FIFO non-empty: pop at the edge, go to SHIFT, and drive beat 0 from that edge.
//     - SHIFT drives beats 0..BEATS-1 on consecutive cycles with pin_z_vld=1.
//     - After beat BEATS-1: if the FIFO is non-empty, pop and start the next word on the next
//       cycle with no gap; otherwise return to IDLE.
//     - In IDLE: pin_z=0 and pin_z_vld=0.
//   Beat ordering follows LSB_FIRST on both paths identically.
//   Reset mid-operation: a partial input word, the holding word, FIFO contents and the
//   in-flight output word are all discarded. err_ovf is cleared.
//   Widths: no arithmetic beyond counters of $clog2(BEATS) and $clog2(FIFO_DEPTH)+1 bits.
//     All counters wrap.
// TESTING (PIN_W=10, CORE_W=40, FIFO_DEPTH=4, LSB_FIRST=1)
//   1. Reset check:
//      assert rst=0 mid-traffic -> all outputs 0 immediately; core_out_rdy=1 after release.
//   2. Deserialise:
//      beats 0x001,0x002,0x003,0x004 with rdy=1 -> core_in_data=40'h01_0030_0801 and
//      vld=1 for 1 cycle.
//   3. Overflow:
//      core_in_rdy=0, send 8 beats -> first word held; second dropped; err_ovf=1 after beat 8.
//      Then rdy=1 -> first word delivered and err_ovf stays 1.
//   4. Serialise:
//      push 40'h01_0030_0801 -> pin_z=0x001,0x002,0x003,0x004 on 4 consecutive cycles with
//      pin_z_vld=1, then 0/0.
//   5. Back-pressure:
//      push 6 words back-to-back -> core_out_rdy drops while full; 24 contiguous output beats
//      with no gaps; no word lost.
//   6. Mid-frame reset:
//      2 beats, pulse rst, then 4 beats 0x3FF -> core_in_data=40'hFF_FFFF_FFFF with no
//      stale slices.

Source files
------------

// File: rtl/wc_pin_bridge.sv
// wc_pin_bridge: pad-side adapter between a narrow pin bus and a wide core data path.
//   Input path : PIN_W-bit beats from the pads are assembled into CORE_W-bit words and
//                presented to the core through a one-word holding register (valid/ready).
//   Output path: core result words enter a FIFO_DEPTH-word FIFO and are shifted out
//                onto the output pins one PIN_W-bit beat per cycle.
// Ports
//   clk, rst                      clock (rising edge), asynchronous active-low reset
//   pin_d, pin_d_vld              input beat from pads (no backpressure)
//   core_in_data/vld/rdy          assembled word to core
//   core_out_data/vld/rdy         result word from core; rdy = FIFO not full
//   pin_z, pin_z_vld              output beat to pads
//   err_ovf                       sticky: an assembled input word was dropped
//
// Serializer states
//   state | meaning
//   IDLE  | no word in flight, pin_z/pin_z_vld held at 0
//   SHIFT | driving beat sh_cnt of sh_word onto pin_z
module wc_pin_bridge #(
  parameter int PIN_W      = 10,
  parameter int CORE_W     = 40,
  parameter int FIFO_DEPTH = 4,
  parameter int LSB_FIRST  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PIN_W-1:0]  pin_d,
  input  logic              pin_d_vld,
  output logic [CORE_W-1:0] core_in_data,
  output logic              core_in_vld,
  input  logic              core_in_rdy,
  input  logic [CORE_W-1:0] core_out_data,
  input  logic              core_out_vld,
  output logic              core_out_rdy,
  output logic [PIN_W-1:0]  pin_z,
  output logic              pin_z_vld,
  output logic              err_ovf
);

  localparam int BEATS = CORE_W / PIN_W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  // Beat number -> slice index within the word; shared by both directions.
  function automatic logic [BW-1:0] slot_of(input logic [BW-1:0] beat);
    return (LSB_FIRST != 0) ? beat : LAST_BEAT - beat;
  endfunction

  // ---------------- input path ----------------
  logic [BW-1:0]     in_cnt;
  logic [BW-1:0]     in_slot;
  logic [CORE_W-1:0] asm_q;
  logic [CORE_W-1:0] asm_next;
  logic [CORE_W-1:0] hold_data;
  logic              hold_vld;
  logic              err_q;
  logic              word_done;

  assign in_slot   = slot_of(in_cnt);
  assign word_done = pin_d_vld && (in_cnt == LAST_BEAT);

  // The completed word includes the beat arriving this cycle, so the holding
  // register can load it on the same edge (no extra latency).
  always_comb begin
    asm_next = asm_q;
    asm_next[int'(in_slot)*PIN_W +: PIN_W] = pin_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_cnt    <= '0;
      asm_q     <= '0;
      hold_data <= '0;
      hold_vld  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (pin_d_vld) begin
        asm_q  <= asm_next;
        in_cnt <= (in_cnt == LAST_BEAT) ? '0 : in_cnt + 1'b1;
      end
      if (word_done && (!hold_vld || core_in_rdy)) begin
        hold_data <= asm_next;
        hold_vld  <= 1'b1;
      end else if (hold_vld && core_in_rdy) begin
        hold_vld <= 1'b0;
      end
      if (word_done && hold_vld && !core_in_rdy) begin
        err_q <= 1'b1;
      end
    end
  end

  assign core_in_data = hold_data;
  assign core_in_vld  = hold_vld;
  assign err_ovf      = err_q;

  // ---------------- output FIFO ----------------
  logic [CORE_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       occ;
  logic              run;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  assign full  = (occ == FULL_CNT);
  assign empty = (occ == '0);
  // run keeps core_out_rdy low while reset is asserted, so every output reads 0 in reset.
  assign core_out_rdy = run && !full;
  assign push  = core_out_vld && core_out_rdy;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= core_out_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run    <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      run <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // ---------------- serializer ----------------
  logic [0:0]        state;
  logic [CORE_W-1:0] sh_word;
  logic [BW-1:0]     sh_cnt;
  logic [BW-1:0]     out_slot;
  logic              at_last;

  assign at_last  = (sh_cnt == LAST_BEAT);
  // Popping on the last beat lets the next word follow with no idle cycle.
  assign pop      = !empty && ((state == IDLE) || at_last);
  assign out_slot = slot_of(sh_cnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      sh_word <= '0;
      sh_cnt  <= '0;
    end else if (pop) begin
      state   <= SHIFT;
      sh_word <= mem[rd_ptr];
      sh_cnt  <= '0;
    end else if (state == SHIFT) begin
      if (at_last) begin
        state <= IDLE;
      end else begin
        sh_cnt <= sh_cnt + 1'b1;
      end
    end
  end

  assign pin_z_vld = (state == SHIFT);
  assign pin_z     = (state == SHIFT) ? sh_word[int'(out_slot)*PIN_W +: PIN_W] : '0;

endmodule
